// File: rtl/quickq_seq_ctrl.sv
// -----------------------------------------------------------------------------
// quickq_seq_ctrl
// Sequencing controller for the QuickQ BRAM priority queue. Entries live in an
// external 1W/1R BRAM with one cycle of read latency. They are sorted by key in
// descending order, so the minimum is always at address size-1. Dequeue reloads
// the head from the new tail slot. Enqueue walks from the tail toward address 0,
// shifting every entry whose key is <= the new key up by one slot, and then
// writes the new entry into the gap.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   enq, deq          requests, sampled only while idle (requests seen while
//                     busy are dropped)
//   kvi               {key,val} entry to enqueue
//   kvo               current minimum entry, valid while !empty
//   full/empty/busy   status flags; size is the current entry count
//   mem_we/mem_waddr/mem_wdata   BRAM write port
//   mem_raddr/mem_rdata          BRAM read port (data arrives the next cycle)
// -----------------------------------------------------------------------------
module quickq_seq_ctrl #(
    parameter int KEY_WIDTH = 8,
    parameter int VAL_WIDTH = 8,
    parameter int CAPACITY  = 16,
    parameter int AW        = $clog2(CAPACITY + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enq,
    input  logic                           deq,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
    output logic                           full,
    output logic                           empty,
    output logic                           busy,
    output logic [AW-1:0]                  size,
    output logic                           mem_we,
    output logic [AW-1:0]                  mem_waddr,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] mem_wdata,
    output logic [AW-1:0]                  mem_raddr,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] mem_rdata
);

    localparam int            EW    = KEY_WIDTH + VAL_WIDTH;
    localparam logic [AW-1:0] CAP_A = AW'(CAPACITY);
    localparam logic [AW-1:0] ONE_A = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD_RD,
        S_HEAD_LD,
        S_INS_RD,
        S_INS_CMP,
        S_INS_WR
    } state_t;

    state_t        state;
    logic [AW-1:0] size_q;
    logic [AW-1:0] idx_q;      // slot currently being examined during insertion
    logic [AW-1:0] pos_q;      // slot the new entry will be written to
    logic          replace_q;  // insertion follows the head reload
    logic [EW-1:0] temp_kv;
    logic [EW-1:0] kvo_q;

    logic accept_deq;
    logic accept_enq;
    logic accept_rep;
    logic shift;

    // Unsigned compare on the key field only.
    function automatic logic key_le(input logic [EW-1:0] a, input logic [EW-1:0] b);
        return a[EW-1 -: KEY_WIDTH] <= b[EW-1 -: KEY_WIDTH];
    endfunction

    assign full  = (size_q == CAP_A);
    assign empty = (size_q == '0);
    assign busy  = (state != S_IDLE);
    assign size  = size_q;
    assign kvo   = kvo_q;

    // Dequeue takes priority; enq together with a valid deq becomes a replace,
    // which is legal even when full because the slot is freed first.
    assign accept_deq = deq && !empty;
    assign accept_enq = enq && !full && !accept_deq;
    assign accept_rep = enq && accept_deq;

    // '<=' moves older equal keys toward the tail, so they leave first.
    assign shift = key_le(mem_rdata, temp_kv);

    // BRAM port drive. The shift write depends on the data read this cycle,
    // so the port is decoded straight from the current state.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_raddr = '0;
        case (state)
            S_HEAD_RD: mem_raddr = size_q - ONE_A;
            S_INS_RD:  mem_raddr = idx_q;
            S_INS_CMP: begin
                if (shift) begin
                    mem_we    = 1'b1;
                    mem_waddr = idx_q + ONE_A;
                    mem_wdata = mem_rdata;
                end
            end
            S_INS_WR: begin
                mem_we    = 1'b1;
                mem_waddr = pos_q;
                mem_wdata = temp_kv;
            end
            default: ;
        endcase
    end

    // Entry being enqueued; pure data, captured on any accept.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && (accept_deq || accept_enq))
            temp_kv <= kvi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            size_q    <= '0;
            idx_q     <= '0;
            pos_q     <= '0;
            replace_q <= 1'b0;
            kvo_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_deq) begin
                        replace_q <= accept_rep;
                        size_q    <= size_q - ONE_A;
                        if (size_q == ONE_A) begin
                            // Queue drains to zero: no head to reload. A replace
                            // drops straight into writing slot 0.
                            if (accept_rep) begin
                                pos_q <= '0;
                                state <= S_INS_WR;
                            end
                        end else begin
                            state <= S_HEAD_RD;
                        end
                    end else if (accept_enq) begin
                        replace_q <= 1'b0;
                        if (empty) begin
                            pos_q <= '0;
                            state <= S_INS_WR;
                        end else begin
                            idx_q <= size_q - ONE_A;
                            state <= S_INS_RD;
                        end
                    end
                end
                S_HEAD_RD: state <= S_HEAD_LD;
                S_HEAD_LD: begin
                    kvo_q <= mem_rdata;
                    if (replace_q) begin
                        idx_q <= size_q - ONE_A;
                        state <= S_INS_RD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_INS_RD: state <= S_INS_CMP;
                S_INS_CMP: begin
                    if (shift) begin
                        if (idx_q == '0) begin
                            pos_q <= '0;
                            state <= S_INS_WR;
                        end else begin
                            idx_q <= idx_q - ONE_A;
                            state <= S_INS_RD;
                        end
                    end else begin
                        pos_q <= idx_q + ONE_A;
                        state <= S_INS_WR;
                    end
                end
                S_INS_WR: begin
                    size_q    <= size_q + ONE_A;
                    replace_q <= 1'b0;
                    // Landing on the tail slot means the new entry is the minimum.
                    if (pos_q == size_q)
                        kvo_q <= temp_kv;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quickq_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_quickq_seq_ctrl
// Bench for quickq_seq_ctrl with a behavioural BRAM and a reference queue held
// in dequeue order (ascending key, older equal keys first).
// -----------------------------------------------------------------------------
module tb_quickq_seq_ctrl;

    localparam int KW  = 8;
    localparam int VW  = 8;
    localparam int CAP = 16;
    localparam int AW  = $clog2(CAP + 1);
    localparam int EW  = KW + VW;

    logic          clk;
    logic          rst;
    logic          enq;
    logic          deq;
    logic [EW-1:0] kvi;
    logic [EW-1:0] kvo;
    logic          full;
    logic          empty;
    logic          busy;
    logic [AW-1:0] size;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [EW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [EW-1:0] mem_rdata;

    logic [EW-1:0] mem [0:(1<<AW)-1];
    logic [EW-1:0] mq[$];

    int vectors;
    int miscompares;
    int stray_we;

    quickq_seq_ctrl #(
        .KEY_WIDTH(KW),
        .VAL_WIDTH(VW),
        .CAPACITY (CAP),
        .AW       (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enq      (enq),
        .deq      (deq),
        .kvi      (kvi),
        .kvo      (kvo),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .size     (size),
        .mem_we   (mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // 1W/1R synchronous BRAM, one cycle read latency.
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    // Any BRAM write outside an operation is illegal.
    always @(negedge clk) begin
        if (mem_we && !busy) stray_we++;
    end

    // Reference model: apply a request, return expected busy cycles and writes.
    task automatic model_op(input logic e, input logic d, input logic [EW-1:0] kv,
                            output int eb, output int ew);
        int n, sh, ex, lat;
        bit dd, de, ins;
        n   = mq.size();
        dd  = d && (n > 0);
        de  = e && (n < CAP) && !dd;
        ins = de || (e && dd);
        ew  = 0;
        ex  = 0;
        if (dd) void'(mq.pop_front());
        if (ins) begin
            sh = 0;
            foreach (mq[j]) if (mq[j][EW-1 -: KW] <= kv[EW-1 -: KW]) sh++;
            ex = (sh < mq.size()) ? sh + 1 : sh;
            mq.insert(sh, kv);
            ew = sh + 1;
        end
        if (dd && !ins)      lat = (n == 1) ? 1 : 3;
        else if (!dd && ins) lat = 2 + 2 * ex;
        else if (dd && ins)  lat = (n == 1) ? 2 : 4 + 2 * ex;
        else                 lat = 1;
        eb = lat - 1;
    endtask

    // Drive one request and count busy cycles / BRAM writes until idle again.
    task automatic do_op(input logic e, input logic d, input logic [EW-1:0] kv,
                         output int bcnt, output int wcnt);
        @(negedge clk);
        enq = e; deq = d; kvi = kv;
        @(posedge clk);
        #1;
        enq = 0; deq = 0;
        bcnt = 0; wcnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) break;
            bcnt++;
            if (mem_we) wcnt++;
        end
        if (busy) begin
            vectors++; miscompares++;
            $display("FAIL op_timeout: busy still %0b after 200 cycles, required 0", busy);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        mq.delete();
    endtask

    task automatic test_reset();
        int b, w, eb, ew;
        do_reset();
        vectors++; if (size !== '0)   begin miscompares++; $display("FAIL rst_size: got %0d need 0", size); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty: got %b need 1", empty); end
        vectors++; if (full !== 1'b0)  begin miscompares++; $display("FAIL rst_full: got %b need 0", full); end
        vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL rst_busy: got %b need 0", busy); end
        vectors++; if (kvo !== '0)     begin miscompares++; $display("FAIL rst_kvo: got %h need 0", kvo); end
        vectors++; if (mem_we !== 1'b0 || mem_waddr !== '0 || mem_raddr !== '0)
            begin miscompares++; $display("FAIL rst_mem: we=%b wa=%0d ra=%0d need 0/0/0", mem_we, mem_waddr, mem_raddr); end
        // deq on empty is ignored
        model_op(0, 1, 16'h0, eb, ew);
        do_op(0, 1, 16'h0, b, w);
        vectors++; if (b !== 0 || w !== 0) begin miscompares++; $display("FAIL deq_empty_busy: busy=%0d we=%0d need 0/0", b, w); end
        vectors++; if (empty !== 1'b1 || kvo !== '0) begin miscompares++; $display("FAIL deq_empty_state: empty=%b kvo=%h need 1/0", empty, kvo); end
    endtask

    task automatic test_basic();
        int b, w, eb, ew;
        logic [EW-1:0] ins_kv [3];
        logic [EW-1:0] exp_kvo [3];
        ins_kv = '{16'h5011, 16'h3022, 16'h7033};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            model_op(1, 0, ins_kv[k], eb, ew);
            do_op(1, 0, ins_kv[k], b, w);
            vectors++; if (b !== eb || w !== ew) begin miscompares++; $display("FAIL enq_timing[%0d]: busy=%0d we=%0d need %0d/%0d", k, b, w, eb, ew); end
        end
        vectors++; if (kvo !== 16'h3022) begin miscompares++; $display("FAIL basic_kvo: got %h need 3022", kvo); end
        vectors++; if (size !== 5'd3) begin miscompares++; $display("FAIL basic_size: got %0d need 3", size); end
        vectors++; if (mem[0] !== 16'h7033 || mem[1] !== 16'h5011 || mem[2] !== 16'h3022)
            begin miscompares++; $display("FAIL basic_mem: got %h %h %h need 7033 5011 3022", mem[0], mem[1], mem[2]); end
        exp_kvo = '{16'h5011, 16'h7033, 16'h0000};
        for (int k = 0; k < 3; k++) begin
            model_op(0, 1, 16'h0, eb, ew);
            do_op(0, 1, 16'h0, b, w);
            vectors++; if (b !== eb || w !== 0) begin miscompares++; $display("FAIL deq_timing[%0d]: busy=%0d we=%0d need %0d/0", k, b, w, eb); end
            if (k < 2) begin
                vectors++; if (kvo !== exp_kvo[k]) begin miscompares++; $display("FAIL deq_kvo[%0d]: got %h need %h", k, kvo, exp_kvo[k]); end
            end
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL basic_drain: empty=%b need 1", empty); end
    endtask

    task automatic test_equal_keys();
        int b, w, eb, ew;
        do_reset();
        model_op(1, 0, 16'h40A1, eb, ew); do_op(1, 0, 16'h40A1, b, w);
        model_op(1, 0, 16'h40B2, eb, ew); do_op(1, 0, 16'h40B2, b, w);
        vectors++; if (kvo !== 16'h40A1) begin miscompares++; $display("FAIL fifo_first: got %h need 40a1", kvo); end
        model_op(0, 1, 16'h0, eb, ew); do_op(0, 1, 16'h0, b, w);
        vectors++; if (kvo !== 16'h40B2) begin miscompares++; $display("FAIL fifo_second: got %h need 40b2", kvo); end
        model_op(0, 1, 16'h0, eb, ew); do_op(0, 1, 16'h0, b, w);
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL fifo_drain: empty=%b need 1", empty); end
    endtask

    task automatic test_full_replace();
        int b, w, eb, ew;
        logic [EW-1:0] kv;
        do_reset();
        for (int k = 0; k < CAP; k++) begin
            kv = {8'($urandom_range(16, 240)), 8'($urandom)};
            model_op(1, 0, kv, eb, ew);
            do_op(1, 0, kv, b, w);
        end
        vectors++; if (full !== 1'b1 || size !== 5'(CAP)) begin miscompares++; $display("FAIL fill: full=%b size=%0d need 1/%0d", full, size, CAP); end
        model_op(1, 0, 16'h0199, eb, ew);
        do_op(1, 0, 16'h0199, b, w);
        vectors++; if (b !== 0 || w !== 0 || size !== 5'(CAP)) begin miscompares++; $display("FAIL enq_full_ignored: busy=%0d we=%0d size=%0d need 0/0/%0d", b, w, size, CAP); end
        model_op(1, 1, 16'h05AB, eb, ew);
        do_op(1, 1, 16'h05AB, b, w);
        vectors++; if (kvo !== 16'h05AB || size !== 5'(CAP)) begin miscompares++; $display("FAIL replace: kvo=%h size=%0d need 05ab/%0d", kvo, size, CAP); end
        vectors++; if (b !== eb || w !== ew) begin miscompares++; $display("FAIL replace_timing: busy=%0d we=%0d need %0d/%0d", b, w, eb, ew); end
        for (int j = 0; j < CAP; j++) begin
            vectors++; if (mem[CAP-1-j] !== mq[j]) begin miscompares++; $display("FAIL replace_mem[%0d]: got %h need %h", CAP-1-j, mem[CAP-1-j], mq[j]); end
        end
    endtask

    task automatic test_new_max();
        int b, w, eb, ew;
        logic [EW-1:0] kv, head;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            kv = {8'($urandom_range(16, 128)), 8'($urandom)};
            model_op(1, 0, kv, eb, ew);
            do_op(1, 0, kv, b, w);
        end
        head = kvo;
        model_op(1, 0, 16'hFF5A, eb, ew);
        do_op(1, 0, 16'hFF5A, b, w);
        vectors++; if (b + 1 !== 18 || eb + 1 !== 18) begin miscompares++; $display("FAIL newmax_latency: got %0d need 18", b + 1); end
        vectors++; if (w !== 9) begin miscompares++; $display("FAIL newmax_writes: got %0d need 9", w); end
        vectors++; if (kvo !== head || mem[0] !== 16'hFF5A) begin miscompares++; $display("FAIL newmax_state: kvo=%h mem0=%h need %h/ff5a", kvo, mem[0], head); end
    endtask

    task automatic test_reset_mid_op();
        int b, w, eb, ew, late_we;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            model_op(1, 0, 16'(k * 16'h1000), eb, ew);
            do_op(1, 0, 16'(k * 16'h1000), b, w);
        end
        @(negedge clk);
        enq = 1; kvi = 16'hF077;
        @(posedge clk);
        #1 enq = 0;
        @(negedge clk);   // INS_RD
        @(negedge clk);   // INS_CMP, first shift
        vectors++; if (mem_we !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL midop_shift: we=%b busy=%b need 1/1", mem_we, busy); end
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        mq.delete();
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || size !== '0 || empty !== 1'b1) begin miscompares++; $display("FAIL midop_reset: busy=%b size=%0d empty=%b need 0/0/1", busy, size, empty); end
        late_we = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_we) late_we++;
        end
        vectors++; if (late_we !== 0) begin miscompares++; $display("FAIL midop_no_we: got %0d writes need 0", late_we); end
    endtask

    task automatic test_random();
        int b, w, eb, ew, r;
        logic e, d;
        logic [EW-1:0] kv;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 9);
            e  = (r < 5) || (r >= 8);
            d  = (r >= 5);
            kv = {8'($urandom_range(0, 7) << 5), 8'($urandom)};
            model_op(e, d, kv, eb, ew);
            do_op(e, d, kv, b, w);
            vectors++; if (b !== eb || w !== ew) begin miscompares++; $display("FAIL rnd_timing[%0d]: busy=%0d we=%0d need %0d/%0d", n, b, w, eb, ew); end
            vectors++; if (size !== 5'(mq.size()) || full !== (mq.size() == CAP) || empty !== (mq.size() == 0))
                begin miscompares++; $display("FAIL rnd_flags[%0d]: size=%0d full=%b empty=%b need %0d", n, size, full, empty, mq.size()); end
            if (mq.size() > 0) begin
                vectors++; if (kvo !== mq[0]) begin miscompares++; $display("FAIL rnd_kvo[%0d]: got %h need %h", n, kvo, mq[0]); end
            end
            foreach (mq[j]) begin
                if (mem[mq.size()-1-j] !== mq[j]) begin
                    vectors++; miscompares++;
                    $display("FAIL rnd_mem[%0d] addr %0d: got %h need %h", n, mq.size()-1-j, mem[mq.size()-1-j], mq[j]);
                end
            end
        end
    endtask

    initial begin
        clk = 0; rst = 1; enq = 0; deq = 0; kvi = '0;
        vectors = 0; miscompares = 0; stray_we = 0;
        test_reset();
        test_basic();
        test_equal_keys();
        test_full_replace();
        test_new_max();
        test_reset_mid_op();
        test_random();
        vectors++; if (stray_we !== 0) begin miscompares++; $display("FAIL stray_we: got %0d writes while idle need 0", stray_we); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
